// File: rtl/serial_subtract_borrow_if.sv
// Handshake and result bundle for the bit-serial subtractor.
// overflow exists only when SERIAL_SUB_OVERFLOW_EN is defined.
interface serial_subtract_borrow_if #(
    parameter int WIDTH = 8
) ();
    logic             start;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrow;
`ifdef SERIAL_SUB_OVERFLOW_EN
    logic             overflow;

    modport master (
        output start, a_in, b_in,
        input  busy, done, diff, borrow, overflow
    );
    modport slave (
        input  start, a_in, b_in,
        output busy, done, diff, borrow, overflow
    );
`else
    modport master (
        output start, a_in, b_in,
        input  busy, done, diff, borrow
    );
    modport slave (
        input  start, a_in, b_in,
        output busy, done, diff, borrow
    );
`endif
endinterface

// File: rtl/serial_subtract_borrow.sv
// Bit-serial A - B, LSB first, one full-subtractor cell plus a borrow flop.
// Optional signed overflow flag: define SERIAL_SUB_OVERFLOW_EN.
module serial_subtract_borrow #(
    parameter int WIDTH = 8
) (
    input logic                    clk,
    input logic                    reset,
    serial_subtract_borrow_if.slave bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] diff_q;
    logic [CW-1:0]    cnt;
    logic             br;
    logic             busy_q;
    logic             done_q;

    logic a0, b0, d, br_next;

    assign a0      = a_sh[0];
    assign b0      = b_sh[0];
    assign d       = a0 ^ b0 ^ br;
    assign br_next = (~a0 & b0) | (~(a0 ^ b0) & br);

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.diff   = diff_q;
    assign bus.borrow = br;

`ifdef SERIAL_SUB_OVERFLOW_EN
    logic ov_q;
    assign bus.overflow = ov_q;

    // Processing the MSB: operands differ in sign and result sign flips.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ov_q <= 1'b0;
        end else if (state == IDLE && bus.start) begin
            ov_q <= 1'b0;
        end else if (state == RUN && cnt == LAST) begin
            ov_q <= (a0 != b0) & (d != a0);
        end
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            a_sh   <= '0;
            b_sh   <= '0;
            diff_q <= '0;
            cnt    <= '0;
            br     <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        a_sh   <= bus.a_in;
                        b_sh   <= bus.b_in;
                        diff_q <= '0;
                        cnt    <= '0;
                        br     <= 1'b0;
                        busy_q <= 1'b1;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    diff_q <= (diff_q >> 1) | (WIDTH'(d) << (WIDTH - 1));
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    br     <= br_next;
                    cnt    <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        state  <= DONE;
                    end
                end
                DONE: begin
                    done_q <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_serial_subtract_borrow.sv
// Bench for serial_subtract_borrow: WIDTH=8 and WIDTH=1 instances
// checked against plain-arithmetic expectations.
module tb_serial_subtract_borrow;
    logic clk;
    logic reset;
    int   errors;
    int   checks;

    serial_subtract_borrow_if #(.WIDTH(8)) b8 ();
    serial_subtract_borrow_if #(.WIDTH(1)) b1 ();

    serial_subtract_borrow #(.WIDTH(8)) dut8 (
        .clk   (clk),
        .reset (reset),
        .bus   (b8)
    );

    serial_subtract_borrow #(.WIDTH(1)) dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (b1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected results from ordinary unsigned/signed arithmetic.
    task automatic op8(input logic [7:0] a, input logic [7:0] b);
        logic [8:0] t;
        int         sd;
        int         n;
        t  = {1'b0, a} - {1'b0, b};
        sd = int'($signed(a)) - int'($signed(b));
        b8.start = 1'b1;
        b8.a_in  = a;
        b8.b_in  = b;
        @(posedge clk); #1;
        b8.start = 1'b0;
        b8.a_in  = 8'($urandom);
        b8.b_in  = 8'($urandom);
        chk("busy8_after_accept", b8.busy, 1);
        n = 0;
        while (!b8.done && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        chk("latency8", n, 8);
        chk("diff8", b8.diff, t[7:0]);
        chk("borrow8", b8.borrow, t[8]);
        chk("busy8_at_done", b8.busy, 0);
`ifdef SERIAL_SUB_OVERFLOW_EN
        chk("overflow8", b8.overflow, (sd > 127 || sd < -128) ? 1 : 0);
`endif
        @(posedge clk); #1;
        chk("done8_one_cycle", b8.done, 0);
    endtask

    task automatic op1(input logic a, input logic b);
        int n;
        b1.start = 1'b1;
        b1.a_in  = a;
        b1.b_in  = b;
        @(posedge clk); #1;
        b1.start = 1'b0;
        chk("busy1_after_accept", b1.busy, 1);
        n = 0;
        while (!b1.done && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        chk("latency1", n, 1);
        chk("diff1", b1.diff, (int'(a) - int'(b)) & 1);
        chk("borrow1", b1.borrow, (a < b) ? 1 : 0);
        @(posedge clk); #1;
        chk("done1_one_cycle", b1.done, 0);
    endtask

    initial begin
        int n;
        int m;
        int pulses;
        logic [7:0] seen_diff;
        logic       seen_borrow;
        errors   = 0;
        checks   = 0;
        reset    = 1'b1;
        b8.start = 1'b0;
        b8.a_in  = '0;
        b8.b_in  = '0;
        b1.start = 1'b0;
        b1.a_in  = '0;
        b1.b_in  = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", b8.busy, 0);
        chk("rst_done", b8.done, 0);
        chk("rst_diff", b8.diff, 0);
        chk("rst_borrow", b8.borrow, 0);
`ifdef SERIAL_SUB_OVERFLOW_EN
        chk("rst_overflow", b8.overflow, 0);
`endif
        reset = 1'b0;
        @(posedge clk); #1;

        op8(8'h05, 8'h03);
        op8(8'h03, 8'h05);
        op8(8'h00, 8'h01);
        op8(8'h80, 8'h01);
        op8(8'h10, 8'h01);
        op8(8'hFF, 8'hFF);
        op8(8'h7F, 8'h80);

        // start pulsed mid-operation must be ignored
        b8.start = 1'b1;
        b8.a_in  = 8'h37;
        b8.b_in  = 8'h12;
        @(posedge clk); #1;
        b8.start = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
        end
        b8.start = 1'b1;
        b8.a_in  = 8'hFF;
        b8.b_in  = 8'h00;
        @(posedge clk); #1;
        b8.start = 1'b0;
        pulses = 0;
        seen_diff = '0;
        seen_borrow = 1'b0;
        for (int i = 0; i < 14; i++) begin
            if (b8.done) begin
                pulses++;
                seen_diff = b8.diff;
                seen_borrow = b8.borrow;
            end
            @(posedge clk); #1;
        end
        chk("ignored_start_pulses", pulses, 1);
        chk("ignored_start_diff", seen_diff, 8'h25);
        chk("ignored_start_borrow", seen_borrow, 0);
        chk("ignored_start_idle", b8.busy, 0);

        // asynchronous reset three cycles into RUN
        b8.start = 1'b1;
        b8.a_in  = 8'h5A;
        b8.b_in  = 8'h33;
        @(posedge clk); #1;
        b8.start = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        reset = 1'b1;
        #1;
        chk("abort_busy", b8.busy, 0);
        chk("abort_diff", b8.diff, 0);
        chk("abort_borrow", b8.borrow, 0);
        chk("abort_done", b8.done, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            if (b8.done) pulses++;
            @(posedge clk); #1;
        end
        chk("abort_no_done", pulses, 0);
        op8(8'h0A, 8'h0A);

        // start held high: re-accepted every WIDTH+2 cycles
        b8.start = 1'b1;
        b8.a_in  = 8'h21;
        b8.b_in  = 8'h42;
        n = 0;
        while (!b8.done && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        chk("held_first_latency", n, 9);
        m = 0;
        do begin
            @(posedge clk); #1;
            m++;
        end while (!b8.done && m < 40);
        chk("held_period", m, 10);
        chk("held_diff", b8.diff, 8'hDF);
        chk("held_borrow", b8.borrow, 1);
        b8.start = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 16; i++) begin
            op8(8'($urandom), 8'($urandom));
        end

        op1(1'b0, 1'b0);
        op1(1'b0, 1'b1);
        op1(1'b1, 1'b0);
        op1(1'b1, 1'b1);
        for (int i = 0; i < 4; i++) begin
            op1(1'($urandom), 1'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
